xrv_mem_arb: RTL
================

# xrv_mem_arb

Shares one single-ported memory bus between the instruction-fetch port and the load/store data port of the xrv core. It sits between `xrv_core` and the unified instruction/data memory. It serialises one transaction at a time. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.

## Interface
Parameters:
- `D_MAX`, default 4: consecutive data grants allowed while a fetch is pending.
- `TIMEOUT`, default 255: read-response watchdog limit, in cycles (8-bit counter). Used only with `XRV_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: fetch request. Held until `i_ready`.
- `i_addr` in 32: fetch address.
- `i_ready` out 1: one-cycle pulse. `i_data` is valid in the same cycle.
- `i_data` out 32: fetched word.
- `d_rd_req` in 1: load request. Held until `d_rd_ready`.
- `d_wr_req` in 1: store request. Held until `d_wr_ready`.
- `d_addr` in 32: data address.
- `d_be` in 4: byte enables.
- `d_wr_data` in 32: store data.
- `d_rd_ready` out 1: load-complete pulse.
- `d_wr_ready` out 1: store-complete pulse.
- `d_rd_data` out 32: load data.
- `m_req` out 1: memory request. Held until `m_gnt`.
- `m_we` out 1: 1 for write, 0 for read.
- `m_addr` out 32: memory address.
- `m_be` out 4: memory byte enables (4'hF for fetch).
- `m_wdata` out 32: memory write data.
- `m_gnt` in 1: memory accepts the request in this cycle.
- `m_rvalid` in 1: read data valid, at least 1 cycle after `m_gnt`.
- `m_rdata` in 32: memory read data.
- `err` out 1: one-cycle pulse on read timeout.

## Operation
- FSM states are IDLE, REQ, WAIT and RESP. Only one memory transaction is outstanding at a time.
- IDLE:
  - Samples the requests and picks a winner.
  - Latches the winner's address, byte enables, write data and type into `m_*` registers, then goes to REQ.
- Priority order:
  1. Data store.
  2. Data load.
  3. Fetch.
- Exception to the priority order: if `i_req` is high and `starve_cnt == D_MAX`, the fetch wins.
- If `d_wr_req` and `d_rd_req` are high together, the store wins. The load remains pending.
- Starvation counter:
  - `starve_cnt` is 3 bits wide and saturating.
  - It increments on each data grant made while `i_req` is high.
  - It clears on a fetch grant, or in IDLE when `i_req` is low.
- REQ: `m_req` is 1. On `m_gnt`:
  - Write: go to RESP.
  - Read: go to WAIT.
- WAIT: on `m_rvalid`, capture `m_rdata` into the response register and go to RESP.
- RESP: pulse exactly one ready (`i_ready`, `d_rd_ready` or `d_wr_ready`) for the owner, then go to IDLE.
- The requester drops its request the cycle after its ready pulse. IDLE never re-grants a request that was already served.
- `i_data` and `d_rd_data` come from the same response register.
  - They are valid only during the corresponding ready cycle.
  - They hold their value otherwise.
- Request inputs are ignored outside IDLE. Address and data changes after the grant decision have no effect.

## Timing
- Reset (asynchronous, in any state, including mid-transaction):
  - State goes to IDLE.
  - `m_req`, `m_we`, all ready outputs and `err` go to 0.
  - `m_addr`, `m_be`, `m_wdata`, `i_data` and `d_rd_data` go to 0.
  - `starve_cnt` goes to 0.
  - An in-flight memory response arriving after reset is ignored.
- Read latency, with `m_gnt` in the first REQ cycle and `m_rvalid` 1 cycle later: request seen in cycle 0, ready in cycle 3.
- Write latency, with immediate `m_gnt`: request seen in cycle 0, `d_wr_ready` in cycle 2.
- Each wait cycle on `m_gnt` or `m_rvalid` adds exactly one cycle.
- Minimum back-to-back interval between grants is 4 cycles for reads and 3 cycles for writes.
- `m_rvalid` is ignored outside WAIT.

## Configuration
- Macro: `XRV_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter runs in WAIT.
  - If `m_rvalid` has not arrived when the count reaches `TIMEOUT`, the FSM goes to RESP.
  - The response register is loaded with 32'h0.
  - The owner's ready pulses normally and `err` pulses in the same cycle.
- Undefined:
  - WAIT lasts indefinitely.
  - `err` is tied to 0.
  - No counter is built.

## Test plan
- Single fetch, addr 32'h100, memory returns 32'h00000013 with gnt at 0 wait and rvalid at +1 → `i_ready` in cycle 3 with `i_data`=32'h13, `m_be`=4'hF, `m_we`=0.
- Store to 32'h2000 with `d_be`=4'b0011 and data 32'hA5A5, gnt held off 2 cycles → `m_req` held for 3 cycles, `d_wr_ready` in cycle 4, `m_we`=1.
- `i_req` and `d_rd_req` raised together → load is granted first and fetch is granted after `d_rd_ready`.
- `i_req` held while 6 back-to-back stores are presented, with `D_MAX`=4 → grant order is D,D,D,D,I,D,D.
- `rst` asserted in WAIT with `m_rvalid` arriving 1 cycle later → all outputs 0 immediately, no ready pulse, next request served normally.
- With `XRV_ARB_TIMEOUT_EN` and `TIMEOUT`=8, `m_rvalid` never arrives → `d_rd_ready` and `err` pulse together 8 cycles after gnt, `d_rd_data`=0. Without the macro, no pulse within 300 cycles.

Source files
------------

// File: rtl/xrv_mem_arb.sv
// Single-ported memory arbiter for xrv: data accesses win, fetch gets a bounded-starvation guarantee.
// Optional read watchdog enabled by defining XRV_ARB_TIMEOUT_EN.
module xrv_mem_arb #(
  parameter int D_MAX   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_rd_ready,
  output logic        d_wr_ready,
  output logic [31:0] d_rd_data,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OWN_I  = 2'd0;
  localparam logic [1:0] OWN_DR = 2'd1;
  localparam logic [1:0] OWN_DW = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  starve_q, starve_d;
  logic        fetch_first;
  logic        data_req;

`ifdef XRV_ARB_TIMEOUT_EN
  logic [7:0]  wcnt_q, wcnt_d;
  logic        to_q, to_d;
`else
  logic        unused_timeout;
  assign unused_timeout = |8'(TIMEOUT);
`endif

  // D_MAX is expected to fit the 3-bit saturating counter (0..7).
  assign fetch_first = i_req && (starve_q == 3'(D_MAX));
  assign data_req    = d_wr_req || d_rd_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    starve_d  = starve_q;
`ifdef XRV_ARB_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    to_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fetch_first || (i_req && !data_req)) begin
          state_d   = S_REQ;
          owner_d   = OWN_I;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_be_d    = 4'hF;
          m_wdata_d = '0;
          starve_d  = '0;
        end else if (data_req) begin
          state_d   = S_REQ;
          owner_d   = d_wr_req ? OWN_DW : OWN_DR;
          m_we_d    = d_wr_req;
          m_addr_d  = d_addr;
          m_be_d    = d_be;
          m_wdata_d = d_wr_req ? d_wr_data : '0;
          if (i_req) starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
          else       starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      S_REQ: begin
        if (m_gnt) begin
          state_d = m_we_q ? S_RESP : S_WAIT;
`ifdef XRV_ARB_TIMEOUT_EN
          wcnt_d  = 8'd1;
`endif
        end
      end
      S_WAIT: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          state_d = S_RESP;
        end
`ifdef XRV_ARB_TIMEOUT_EN
        // Counter holds cycles elapsed since the grant edge.
        else if (wcnt_q == 8'(TIMEOUT - 1)) begin
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_I;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      starve_q  <= '0;
`ifdef XRV_ARB_TIMEOUT_EN
      wcnt_q    <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      starve_q  <= starve_d;
`ifdef XRV_ARB_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      to_q      <= to_d;
`endif
    end
  end

  assign m_req      = (state_q == S_REQ);
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_be       = m_be_q;
  assign m_wdata    = m_wdata_q;
  assign i_ready    = (state_q == S_RESP) && (owner_q == OWN_I);
  assign d_rd_ready = (state_q == S_RESP) && (owner_q == OWN_DR);
  assign d_wr_ready = (state_q == S_RESP) && (owner_q == OWN_DW);
  assign i_data     = rdata_q;
  assign d_rd_data  = rdata_q;

`ifdef XRV_ARB_TIMEOUT_EN
  assign err = (state_q == S_RESP) && to_q;
`else
  assign err = 1'b0;
`endif

endmodule
